// File: rtl/i2c_cfg_sequencer.sv
// i2c_cfg_sequencer: walks a ROM configuration table and feeds I2C command words to the master FIFO
module i2c_cfg_sequencer #(
    parameter int CLK_FREQ_MHZ   = 100,
    parameter int TIMEOUT_US     = 10000,
    parameter int ROM_ADDR_WIDTH = 8,
    parameter int MAX_RETRY      = 2
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic                      start,
    output logic                      busy,
    output logic                      done,
    output logic                      error,
    output logic [ROM_ADDR_WIDTH-1:0] err_index,
    output logic [7:0]                mismatch_cnt,
    output logic                      rom_en,
    output logic [ROM_ADDR_WIDTH-1:0] rom_addr,
    input  logic [33:0]               rom_data,
    output logic [55:0]               fifo_din,
    output logic                      fifo_wr_en,
    input  logic                      fifo_full,
    input  logic                      wr_data_success,
    input  logic [7:0]                rdata,
    input  logic                      rdata_valid
);
    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] FETCH = 3'd1;
    localparam logic [2:0] LATCH = 3'd2;
    localparam logic [2:0] PUSH  = 3'd3;
    localparam logic [2:0] WAIT  = 3'd4;
    localparam logic [2:0] NEXT  = 3'd5;
    localparam logic [2:0] DONE  = 3'd6;
    localparam logic [2:0] ERR   = 3'd7;
    // The counter holds cycles spent in WAIT; the attempt expires when the next count reaches TERM,
    // so consecutive re-issues of one entry are exactly the timeout period apart.
    localparam logic [31:0] TERM = 32'(CLK_FREQ_MHZ * TIMEOUT_US - 1);
    localparam logic [3:0] RETRY_MAX = 4'(MAX_RETRY);
    localparam logic [ROM_ADDR_WIDTH-1:0] IDX_LAST = '1;

    logic [2:0]                state_q, state_d;
    logic [ROM_ADDR_WIDTH-1:0] idx_q, idx_d, err_index_q, err_index_d;
    logic [3:0]                retry_q, retry_d;
    logic [31:0]               cnt_q, cnt_d;
    logic [33:0]               entry_q, entry_d;
    logic                      error_q, error_d;
    logic [7:0]                mismatch_q, mismatch_d;
    logic                      cmpl, expired;

    // entry bit 32 selects which completion strobe belongs to the in-flight transaction
    assign cmpl    = entry_q[32] ? rdata_valid : wr_data_success;
    assign expired = (cnt_q + 32'd1) >= TERM;

    assign busy         = (state_q != IDLE) && (state_q != DONE) && (state_q != ERR);
    assign done         = state_q == DONE;
    assign error        = error_q;
    assign err_index    = err_index_q;
    assign mismatch_cnt = mismatch_q;
    assign rom_en       = state_q == FETCH;
    assign rom_addr     = rom_en ? idx_q : '0;
    assign fifo_wr_en   = (state_q == PUSH) && !fifo_full;
    assign fifo_din     = fifo_wr_en ? {entry_q[32], entry_q[31], 7'd0, entry_q[30:0], 16'd0} : '0;

    // sequencer next-state: table walk, push, completion/timeout/retry handling
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        retry_d     = retry_q;
        cnt_d       = cnt_q;
        entry_d     = entry_q;
        error_d     = error_q;
        err_index_d = err_index_q;
        mismatch_d  = mismatch_q;
        case (state_q)
            IDLE: if (start) begin
                state_d     = FETCH;
                idx_d       = '0;
                retry_d     = '0;
                error_d     = 1'b0;
                err_index_d = '0;
                mismatch_d  = '0;
            end
            FETCH: state_d = LATCH;
            LATCH: begin
                entry_d = rom_data;
                state_d = PUSH;
            end
            PUSH: if (!fifo_full) begin
                cnt_d   = '0;
                state_d = WAIT;
            end
            WAIT: if (cmpl) begin
                if (entry_q[32] && (rdata != entry_q[7:0]) && (mismatch_q != 8'hFF))
                    mismatch_d = mismatch_q + 8'd1;
                state_d = NEXT;
            end else if (expired) begin
                if (retry_q < RETRY_MAX) begin
                    retry_d = retry_q + 4'd1;
                    state_d = PUSH;
                end else begin
                    error_d     = 1'b1;
                    err_index_d = idx_q;
                    state_d     = ERR;
                end
            end else begin
                cnt_d = cnt_q + 32'd1;
            end
            NEXT: begin
                retry_d = '0;
                state_d = (entry_q[33] || (idx_q == IDX_LAST)) ? DONE : FETCH;
                idx_d   = (entry_q[33] || (idx_q == IDX_LAST)) ? idx_q : idx_q + ROM_ADDR_WIDTH'(1);
            end
            default: state_d = IDLE;
        endcase
    end

    // state registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            retry_q     <= '0;
            cnt_q       <= '0;
            entry_q     <= '0;
            error_q     <= 1'b0;
            err_index_q <= '0;
            mismatch_q  <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            retry_q     <= retry_d;
            cnt_q       <= cnt_d;
            entry_q     <= entry_d;
            error_q     <= error_d;
            err_index_q <= err_index_d;
            mismatch_q  <= mismatch_d;
        end
    end
endmodule

// File: tb/tb_i2c_cfg_sequencer.sv
// tb_i2c_cfg_sequencer: table vectors plus scoreboarded multi-cycle sequences for the config sequencer
module tb_i2c_cfg_sequencer;
    localparam int AW = 4;

    typedef struct {
        logic [33:0] entry;
        logic [7:0]  rd;
        logic [55:0] word;
        logic [7:0]  mm;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rstn, start_a, start_b, fifo_full, inj_rd;
    logic          resp_wr, resp_rd, rdata_valid;
    logic [7:0]    resp_data, inj_data, rdata;
    logic [33:0]   rom [16];
    logic [33:0]   rom_q_a, rom_q_b;
    logic          a_busy, a_done, a_error, a_ren, a_wen, b_busy, b_done, b_error, b_ren, b_wen;
    logic [AW-1:0] a_eidx, a_raddr, b_eidx, b_raddr;
    logic [7:0]    a_mm, b_mm;
    logic [55:0]   a_din, b_din;
    logic [76:0]   a_all, b_all;

    int          total = 0, bad = 0, pushes = 0, cyc = 0, a_done_n = 0, b_done_n = 0;
    int          resp_limit = 0, resp_used = 0, resp_delay = 50, pend = 0;
    int          push_t[$];
    logic [55:0] exp_q[$];
    logic [7:0]  rd_vals[$];
    logic        pend_rw = 1'b0, prev_wen = 1'b0;

    assign rdata_valid = resp_rd | inj_rd;
    assign rdata       = inj_rd ? inj_data : resp_data;
    assign a_all = {a_busy, a_done, a_error, a_eidx, a_mm, a_ren, a_raddr, a_din, a_wen};
    assign b_all = {b_busy, b_done, b_error, b_eidx, b_mm, b_ren, b_raddr, b_din, b_wen};

    i2c_cfg_sequencer #(.CLK_FREQ_MHZ(1), .TIMEOUT_US(200), .ROM_ADDR_WIDTH(AW), .MAX_RETRY(2)) dut_a (
        .clk(clk), .rstn(rstn), .start(start_a), .busy(a_busy), .done(a_done), .error(a_error),
        .err_index(a_eidx), .mismatch_cnt(a_mm), .rom_en(a_ren), .rom_addr(a_raddr), .rom_data(rom_q_a),
        .fifo_din(a_din), .fifo_wr_en(a_wen), .fifo_full(fifo_full), .wr_data_success(resp_wr),
        .rdata(rdata), .rdata_valid(rdata_valid));

    i2c_cfg_sequencer #(.CLK_FREQ_MHZ(1), .TIMEOUT_US(20), .ROM_ADDR_WIDTH(AW), .MAX_RETRY(2)) dut_b (
        .clk(clk), .rstn(rstn), .start(start_b), .busy(b_busy), .done(b_done), .error(b_error),
        .err_index(b_eidx), .mismatch_cnt(b_mm), .rom_en(b_ren), .rom_addr(b_raddr), .rom_data(rom_q_b),
        .fifo_din(b_din), .fifo_wr_en(b_wen), .fifo_full(fifo_full), .wr_data_success(resp_wr),
        .rdata(rdata), .rdata_valid(rdata_valid));

    // synchronous table ROM, one per sequencer read port
    always @(posedge clk) begin
        if (a_ren) rom_q_a <= rom[a_raddr];
        if (b_ren) rom_q_b <= rom[b_raddr];
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_end(input bit use_b, input int maxc, output bit got);
        got = 1'b0;
        for (int i = 0; i < maxc && !got; i++) begin
            step(1);
            got = use_b ? (b_done | b_error) : (a_done | a_error);
        end
        total++;
        if (!got) begin
            bad++;
            $display("FAIL wait_end: no done/error within %0d cycles", maxc);
        end
    endtask

    function automatic logic [33:0] mk(input logic last, input logic rw, input logic a16,
                                       input logic [6:0] dev, input logic [15:0] da, input logic [7:0] d);
        return {last, rw, a16, dev, da, d};
    endfunction

    // master model: answers each push after resp_delay cycles while the response budget lasts
    always @(negedge clk) begin
        resp_wr = 1'b0;
        resp_rd = 1'b0;
        if (pend > 0) begin
            pend--;
            if (pend == 0) begin
                if (pend_rw) begin
                    resp_rd   = 1'b1;
                    resp_data = (rd_vals.size() > 0) ? rd_vals.pop_front() : 8'h00;
                end else begin
                    resp_wr = 1'b1;
                end
            end
        end
        if ((a_wen || b_wen) && resp_used < resp_limit) begin
            resp_used++;
            pend    = resp_delay;
            pend_rw = a_wen ? a_din[55] : b_din[55];
        end
    end

    // push monitor: scoreboard compare, back-to-back strobe check, push timestamps
    always @(negedge clk) begin
        cyc++;
        if (a_done) a_done_n++;
        if (b_done) b_done_n++;
        if (a_wen || b_wen) begin
            pushes++;
            if (b_wen) push_t.push_back(cyc);
            check("wen_back_to_back", 128'(prev_wen), 128'(0));
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL push_extra: got %0h expected no push", a_wen ? a_din : b_din);
            end else begin
                check("push_word", 128'(a_wen ? a_din : b_din), 128'(exp_q.pop_front()));
            end
        end
        prev_wen = a_wen | b_wen;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v[5];
        int   p0, d0, n0, hits;
        bit   got;
        v[0] = '{mk(1'b1, 1'b0, 1'b0, 7'h50, 16'h0012, 8'hA5), 8'h00, 56'h00_50_0012_A5_0000, 8'd0};
        v[1] = '{mk(1'b1, 1'b0, 1'b1, 7'h7F, 16'hBEEF, 8'h01), 8'h00, 56'h40_7F_BEEF_01_0000, 8'd0};
        v[2] = '{mk(1'b1, 1'b1, 1'b0, 7'h21, 16'h0003, 8'h5A), 8'h5B, 56'h80_21_0003_5A_0000, 8'd1};
        v[3] = '{mk(1'b1, 1'b1, 1'b1, 7'h00, 16'hFFFF, 8'h11), 8'h11, 56'hC0_00_FFFF_11_0000, 8'd0};
        v[4] = '{mk(1'b1, 1'b0, 1'b1, 7'h2A, 16'h8001, 8'hFF), 8'h00, 56'h40_2A_8001_FF_0000, 8'd0};
        rstn = 1'b0; start_a = 1'b0; start_b = 1'b0; fifo_full = 1'b0; inj_rd = 1'b0; inj_data = 8'h00;
        resp_limit = 32'h7FFF_FFFF;
        for (int i = 0; i < 16; i++) rom[i] = '0;
        step(3);
        check("reset_a_outputs", 128'(a_all), 128'(0));
        check("reset_b_outputs", 128'(b_all), 128'(0));
        rstn = 1'b1;
        step(1);

        // single-entry table vectors
        for (int i = 0; i < 5; i++) begin
            rom[0] = v[i].entry;
            exp_q.push_back(v[i].word);
            if (v[i].entry[32]) rd_vals.push_back(v[i].rd);
            start_a = 1'b1; step(1); start_a = 1'b0;
            wait_end(1'b0, 300, got);
            check($sformatf("vec%0d_end", i), 128'({a_done, a_error, a_busy}), 128'(3'b100));
            check($sformatf("vec%0d_mismatch", i), 128'(a_mm), 128'(v[i].mm));
            step(2);
        end

        // three-entry write table, last flag on idx 2
        rom[0] = mk(1'b0, 1'b0, 1'b0, 7'h1A, 16'h0100, 8'h11);
        rom[1] = mk(1'b0, 1'b0, 1'b1, 7'h1A, 16'h0201, 8'h22);
        rom[2] = mk(1'b1, 1'b0, 1'b0, 7'h3C, 16'h00FE, 8'h33);
        rom[3] = mk(1'b1, 1'b0, 1'b0, 7'h7E, 16'hDEAD, 8'h44);
        exp_q.push_back(56'h00_1A_0100_11_0000);
        exp_q.push_back(56'h40_1A_0201_22_0000);
        exp_q.push_back(56'h00_3C_00FE_33_0000);
        p0 = pushes; d0 = a_done_n;
        start_a = 1'b1; step(1); start_a = 1'b0;
        check("t1_fetch", 128'({a_busy, a_ren, a_raddr}), 128'(6'b110000));
        step(1);
        check("t1_latch_no_wen", 128'(a_wen), 128'(0));
        step(1);
        check("t1_first_push", 128'(a_wen), 128'(1));
        wait_end(1'b0, 600, got);
        check("t1_end", 128'({a_done, a_error}), 128'(2'b10));
        step(1);
        check("t1_push_count", 128'(pushes - p0), 128'(3));
        check("t1_done_once", 128'(a_done_n - d0), 128'(1));
        check("t1_idle_after", 128'({a_busy, a_done}), 128'(0));

        // read mismatch then read match
        rom[0] = mk(1'b0, 1'b1, 1'b0, 7'h21, 16'h0040, 8'h5A);
        rom[1] = mk(1'b1, 1'b1, 1'b1, 7'h21, 16'h1234, 8'h11);
        exp_q.push_back(56'h80_21_0040_5A_0000);
        exp_q.push_back(56'hC0_21_1234_11_0000);
        rd_vals.push_back(8'h5B);
        rd_vals.push_back(8'h11);
        start_a = 1'b1; step(1); start_a = 1'b0;
        wait_end(1'b0, 400, got);
        check("t2_end", 128'({a_done, a_error}), 128'(2'b10));
        check("t2_mismatch", 128'(a_mm), 128'(1));
        step(2);

        // FIFO full held at PUSH
        rom[0] = mk(1'b1, 1'b0, 1'b0, 7'h05, 16'h0A0B, 8'h0C);
        exp_q.push_back(56'h00_05_0A0B_0C_0000);
        fifo_full = 1'b1; p0 = pushes; hits = 0;
        start_a = 1'b1; step(1); start_a = 1'b0;
        step(2);
        for (int i = 0; i < 10; i++) begin
            if (a_wen) hits++;
            step(1);
        end
        check("t3_full_hold", 128'(hits + pushes - p0), 128'(0));
        fifo_full = 1'b0;
        #1;
        check("t3_release_push", 128'(a_wen), 128'(1));
        wait_end(1'b0, 200, got);
        check("t3_end", 128'({a_done, a_error}), 128'(2'b10));
        check("t3_push_count", 128'(pushes - p0), 128'(1));
        step(2);

        // restart pulse and foreign read strobes during a write entry
        rom[0] = mk(1'b0, 1'b0, 1'b0, 7'h33, 16'h0001, 8'h77);
        rom[1] = mk(1'b1, 1'b0, 1'b0, 7'h33, 16'h0002, 8'h88);
        exp_q.push_back(56'h00_33_0001_77_0000);
        exp_q.push_back(56'h00_33_0002_88_0000);
        p0 = pushes;
        start_a = 1'b1; step(1); start_a = 1'b0;
        for (int i = 0; i < 10 && !a_wen; i++) step(1);
        check("t4_push_seen", 128'(a_wen), 128'(1));
        step(1);
        start_a = 1'b1; step(1); start_a = 1'b0;
        for (int i = 0; i < 16; i++) begin
            inj_rd = 1'b1; inj_data = 8'(i);
            step(1);
            inj_rd = 1'b0;
            step(1);
        end
        wait_end(1'b0, 400, got);
        check("t4_end", 128'({a_done, a_error}), 128'(2'b10));
        check("t4_mismatch", 128'(a_mm), 128'(0));
        check("t4_push_count", 128'(pushes - p0), 128'(2));
        step(2);

        // timeout with retries on idx 1 (20-cycle timeout instance)
        rom[0] = mk(1'b0, 1'b0, 1'b0, 7'h44, 16'h0010, 8'h01);
        rom[1] = mk(1'b1, 1'b0, 1'b1, 7'h44, 16'h0020, 8'h02);
        exp_q.push_back(56'h00_44_0010_01_0000);
        for (int i = 0; i < 3; i++) exp_q.push_back(56'h40_44_0020_02_0000);
        resp_delay = 5; resp_limit = resp_used + 1;
        n0 = push_t.size(); d0 = b_done_n;
        start_b = 1'b1; step(1); start_b = 1'b0;
        wait_end(1'b1, 300, got);
        check("t5_end", 128'({b_done, b_error, b_busy, b_eidx}), 128'(7'b010_0001));
        check("t5_push_count", 128'(push_t.size() - n0), 128'(4));
        if (push_t.size() - n0 >= 4) begin
            check("t5_retry_gap1", 128'(push_t[n0 + 2] - push_t[n0 + 1]), 128'(20));
            check("t5_retry_gap2", 128'(push_t[n0 + 3] - push_t[n0 + 2]), 128'(20));
        end
        step(3);
        check("t5_error_sticky", 128'({b_error, b_eidx, b_busy}), 128'(6'b1_0001_0));
        check("t5_no_done", 128'(b_done_n - d0), 128'(0));
        resp_limit = 32'h7FFF_FFFF;

        // table without last flag ends at the final index
        resp_delay = 3; p0 = pushes;
        for (int i = 0; i < 16; i++) begin
            rom[i] = mk(1'b0, 1'b0, 1'b0, 7'h10, 16'(i), 8'(i * 3));
            exp_q.push_back({8'h00, 8'h10, 16'(i), 8'(i * 3), 16'h0000});
        end
        start_a = 1'b1; step(1); start_a = 1'b0;
        wait_end(1'b0, 600, got);
        check("t6_end", 128'({a_done, a_error}), 128'(2'b10));
        check("t6_push_count", 128'(pushes - p0), 128'(16));
        step(2);

        // reset while waiting on idx 1, then restart from idx 0
        rom[0] = mk(1'b0, 1'b0, 1'b0, 7'h55, 16'h0100, 8'h99);
        rom[1] = mk(1'b1, 1'b0, 1'b0, 7'h55, 16'h0101, 8'h9A);
        exp_q.push_back(56'h00_55_0100_99_0000);
        exp_q.push_back(56'h00_55_0101_9A_0000);
        resp_limit = resp_used + 1; p0 = pushes;
        start_a = 1'b1; step(1); start_a = 1'b0;
        for (int i = 0; i < 100 && (pushes - p0) < 2; i++) step(1);
        step(5);
        check("t7_in_wait", 128'({a_busy, a_raddr}), 128'(5'b1_0000));
        rstn = 1'b0;
        step(1);
        check("t7_reset_outputs", 128'(a_all), 128'(0));
        rstn = 1'b1; resp_limit = 32'h7FFF_FFFF;
        exp_q.push_back(56'h00_55_0100_99_0000);
        exp_q.push_back(56'h00_55_0101_9A_0000);
        step(1);
        start_a = 1'b1; step(1); start_a = 1'b0;
        check("t7_restart_fetch", 128'({a_busy, a_ren, a_raddr}), 128'(6'b110000));
        wait_end(1'b0, 200, got);
        check("t7_end", 128'({a_done, a_error}), 128'(2'b10));
        step(2);
        check("scoreboard_drained", 128'(exp_q.size()), 128'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
